clutter_gate: RTL and testbench

Radar clutter-removal stage directly downstream of the background-model stage. It compares each incoming intensity sample against the running noise threshold plus a fixed margin. It requires a run of consecutive hits before declaring a target, then streams the confirmed target samples, tagged with their sample index, through a small output FIFO with a valid/ready handshake. The stage absorbs downstream back-pressure without stalling the sample stream.

---
 rtl/clutter_gate.sv | 181 ++++++++++++++++++
 tb/tb_clutter_gate.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/clutter_gate.sv
// clutter_gate: radar clutter-removal stage.
//
// Each valid sample is compared against (threshold + MARGIN), saturated to
// 16 bits. PERSIST consecutive hits confirm a target. While confirmed, every
// hit sample is pushed into a small output FIFO together with its sample
// index. The input never stalls. A detection that finds the FIFO full, with
// no pop in the same cycle, is dropped and sets the sticky overflow flag.
//
// Optional build macro: CLUTTER_GATE_HYST_EN. When it is defined, the
// confirmed state is left only when intensity <= threshold; the margin is
// not applied on exit.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   valid_in      in   sample strobe (no back-pressure)
//   intensity     in   [15:0] unsigned sample intensity
//   threshold     in   [15:0] noise threshold for this sample
//   out_valid     out  FIFO non-empty
//   out_ready     in   downstream accept
//   out_intensity out  [15:0] head-of-FIFO intensity
//   out_index     out  [15:0] head-of-FIFO sample index
//   confirmed     out  state machine is in CONF
//   overflow      out  sticky; a detection was dropped
module clutter_gate #(
    parameter logic [15:0] MARGIN  = 16'd32,
    parameter int          PERSIST = 3,
    parameter int          DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        valid_in,
    input  logic [15:0] intensity,
    input  logic [15:0] threshold,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_intensity,
    output logic [15:0] out_index,
    output logic        confirmed,
    output logic        overflow
);

    localparam int         AW        = $clog2(DEPTH);
    localparam logic [3:0] PERSIST_N = 4'(PERSIST);

    typedef enum logic [1:0] {IDLE, CAND, CONF} state_t;

    state_t      state_q, state_d;
    logic [3:0]  run_q, run_d;
    logic [15:0] idx_q;
    logic        emit;

    // Hit test. The sum is formed at 17 bits so that a carry saturates
    // thr_hi to all ones; no 16-bit intensity can then exceed it.
    logic [16:0] thr_sum;
    logic [15:0] thr_hi;
    logic        hit;
    logic        conf_keep;

    assign thr_sum = {1'b0, threshold} + {1'b0, MARGIN};
    assign thr_hi  = thr_sum[16] ? 16'hFFFF : thr_sum[15:0];
    assign hit     = intensity > thr_hi;

`ifdef CLUTTER_GATE_HYST_EN
    // Once confirmed, any sample above the bare threshold keeps the target.
    assign conf_keep = intensity > threshold;
`else
    assign conf_keep = hit;
`endif

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        emit    = 1'b0;
        if (valid_in) begin
            case (state_q)
                IDLE: begin
                    if (hit) begin
                        run_d = 4'd1;
                        if (PERSIST_N == 4'd1) begin
                            state_d = CONF;
                            emit    = 1'b1;
                        end else begin
                            state_d = CAND;
                        end
                    end
                end
                CAND: begin
                    if (hit) begin
                        run_d = run_q + 4'd1;
                        if (run_q + 4'd1 == PERSIST_N) begin
                            state_d = CONF;
                            emit    = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                        run_d   = 4'd0;
                    end
                end
                CONF: begin
                    if (conf_keep) begin
                        emit = 1'b1;
                    end else begin
                        state_d = IDLE;
                        run_d   = 4'd0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    run_d   = 4'd0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            run_q   <= 4'd0;
            idx_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            if (valid_in) begin
                idx_q <= idx_q + 16'd1;  // wraps naturally at 16'hFFFF
            end
        end
    end

    // Output FIFO. The pointers carry one extra wrap bit so that full and
    // empty can be told apart.
    logic [AW:0] wr_ptr, rd_ptr;
    logic [15:0] mem_int [DEPTH];
    logic [15:0] mem_idx [DEPTH];
    logic        empty, full, pop, push, drop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && out_ready;
    // A pop frees the slot in the same cycle, so a push into a full FIFO
    // is accepted when a pop happens alongside it.
    assign push  = emit && (!full || pop);
    assign drop  = emit && full && !pop;

    // NOTE: the storage is reset here because the head-of-FIFO outputs must
    // read zero after reset. At this depth the extra flops are cheap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_int[i] <= 16'd0;
                mem_idx[i] <= 16'd0;
            end
        end else begin
            if (push) begin
                mem_int[wr_ptr[AW-1:0]] <= intensity;
                mem_idx[wr_ptr[AW-1:0]] <= idx_q;
                wr_ptr                  <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign out_valid     = !empty;
    assign out_intensity = mem_int[rd_ptr[AW-1:0]];
    assign out_index     = mem_idx[rd_ptr[AW-1:0]];
    assign confirmed     = (state_q == CONF);

endmodule

// File: tb/tb_clutter_gate.sv
// Directed, table-driven bench for clutter_gate with default parameters
// (MARGIN=32, PERSIST=3, DEPTH=4). Each record is one clock cycle: the
// inputs to drive and the outputs expected just after the rising edge.
// Head data is compared only when the FIFO is expected to be non-empty.
module tb_clutter_gate;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid_in;
    logic [15:0] intensity;
    logic [15:0] threshold;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_intensity;
    logic [15:0] out_index;
    logic        confirmed;
    logic        overflow;

    int n_cmp = 0;
    int n_bad = 0;

    clutter_gate dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .valid_in      (valid_in),
        .intensity     (intensity),
        .threshold     (threshold),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_intensity (out_intensity),
        .out_index     (out_index),
        .confirmed     (confirmed),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;    // apply a reset before this cycle
        logic        v;
        logic [15:0] inten;
        logic [15:0] thr;
        logic        rdy;
        logic        e_ov;
        logic [15:0] e_int;
        logic [15:0] e_idx;
        logic        e_conf;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic v,
                                input logic [15:0] inten, input logic [15:0] thr,
                                input logic rdy, input logic e_ov,
                                input logic [15:0] e_int, input logic [15:0] e_idx,
                                input logic e_conf, input logic e_ovf);
        vec_t r;
        r.rst = rst; r.v = v; r.inten = inten; r.thr = thr; r.rdy = rdy;
        r.e_ov = e_ov; r.e_int = e_int; r.e_idx = e_idx;
        r.e_conf = e_conf; r.e_ovf = e_ovf;
        vecs.push_back(r);
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        valid_in  = 1'b0;
        intensity = 16'd0;
        threshold = 16'd0;
        out_ready = 1'b0;
        #1;
        check("reset_outputs",
              64'({out_valid, out_intensity, out_index, confirmed, overflow}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic step(input logic v, input logic [15:0] inten,
                        input logic [15:0] thr, input logic rdy);
        @(negedge clk);
        valid_in  = v;
        intensity = inten;
        threshold = thr;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b1;
        valid_in  = 1'b0;
        intensity = 16'd0;
        threshold = 16'd0;
        out_ready = 1'b0;

        // Basic detection: confirming sample is idx3, run ends on idx5.
        add(1, 1,  50, 100, 1,  0,   0, 0, 0, 0);
        add(0, 1, 140, 100, 1,  0,   0, 0, 0, 0);
        add(0, 1, 140, 100, 1,  0,   0, 0, 0, 0);
        add(0, 1, 140, 100, 1,  1, 140, 3, 1, 0);
        add(0, 1, 140, 100, 1,  1, 140, 4, 1, 0);
        add(0, 1,  50, 100, 1,  0,   0, 0, 0, 0);

        // Broken run: only idx5 confirms; an idle cycle keeps CONF.
        add(1, 1, 140, 100, 1,  0,   0, 0, 0, 0);
        add(0, 1, 140, 100, 1,  0,   0, 0, 0, 0);
        add(0, 1,  90, 100, 1,  0,   0, 0, 0, 0);
        add(0, 1, 140, 100, 1,  0,   0, 0, 0, 0);
        add(0, 1, 140, 100, 1,  0,   0, 0, 0, 0);
        add(0, 1, 140, 100, 1,  1, 140, 5, 1, 0);
        add(0, 0,   0, 100, 1,  0,   0, 0, 1, 0);

        // Strict compare boundary: thr_hi = 132, so 133 hits and 132 misses.
        add(1, 1, 133, 100, 1,  0,   0, 0, 0, 0);
        add(0, 1, 133, 100, 1,  0,   0, 0, 0, 0);
        add(0, 1, 133, 100, 1,  1, 133, 2, 1, 0);
`ifdef CLUTTER_GATE_HYST_EN
        add(0, 1, 132, 100, 1,  1, 132, 3, 1, 0);
`else
        add(0, 1, 132, 100, 1,  0,   0, 0, 0, 0);
`endif

        // Saturation: thr_hi clamps to 16'hFFFF, so nothing ever hits.
        add(1, 1, 16'hFFFF, 16'hFFF0, 1,  0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++)
            add(0, 1, 16'hFFFF, 16'hFFF0, 1,  0, 0, 0, 0, 0);
        // thr_hi lands exactly on 16'hFFFF without a carry.
        for (int i = 0; i < 3; i++)
            add(0, 1, 16'hFFFF, 16'hFFDF, 1,  0, 0, 0, 0, 0);

        // Back-pressure: idx2..idx5 fill the FIFO, idx6/idx7 are dropped.
        add(1, 1, 200, 100, 0,  0,   0, 0, 0, 0);
        add(0, 1, 200, 100, 0,  0,   0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            add(0, 1, 200, 100, 0,  1, 200, 2, 1, 0);
        add(0, 1, 200, 100, 0,  1, 200, 2, 1, 1);
        add(0, 1, 200, 100, 0,  1, 200, 2, 1, 1);
        // Drain: exactly four entries, in order.
        add(0, 0,   0, 100, 1,  1, 200, 3, 1, 1);
        add(0, 0,   0, 100, 1,  1, 200, 4, 1, 1);
        add(0, 0,   0, 100, 1,  1, 200, 5, 1, 1);
        add(0, 0,   0, 100, 1,  0,   0, 0, 1, 1);

        // Full FIFO with push and pop together: idx6 must survive.
        add(1, 1, 200, 100, 0,  0,   0, 0, 0, 0);
        add(0, 1, 200, 100, 0,  0,   0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            add(0, 1, 200, 100, 0,  1, 200, 2, 1, 0);
        add(0, 1, 200, 100, 1,  1, 200, 3, 1, 0);
        add(0, 0,   0, 100, 1,  1, 200, 4, 1, 0);
        add(0, 0,   0, 100, 1,  1, 200, 5, 1, 0);
        add(0, 0,   0, 100, 1,  1, 200, 6, 1, 0);
        add(0, 0,   0, 100, 1,  0,   0, 0, 1, 0);

        // Hysteresis: 120 sits between threshold and thr_hi.
        add(1, 1, 140, 100, 1,  0,   0, 0, 0, 0);
        add(0, 1, 140, 100, 1,  0,   0, 0, 0, 0);
        add(0, 1, 140, 100, 1,  1, 140, 2, 1, 0);
`ifdef CLUTTER_GATE_HYST_EN
        add(0, 1, 120, 100, 1,  1, 120, 3, 1, 0);
`else
        add(0, 1, 120, 100, 1,  0,   0, 0, 0, 0);
`endif
        add(0, 1,  90, 100, 1,  0,   0, 0, 0, 0);

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            step(vecs[i].v, vecs[i].inten, vecs[i].thr, vecs[i].rdy);
            check($sformatf("vec%0d_status", i),
                  64'({out_valid, confirmed, overflow}),
                  64'({vecs[i].e_ov, vecs[i].e_conf, vecs[i].e_ovf}));
            if (vecs[i].e_ov)
                check($sformatf("vec%0d_head", i),
                      64'({out_intensity, out_index}),
                      64'({vecs[i].e_int, vecs[i].e_idx}));
        end

        // Mid-stream reset: two entries queued, then an asynchronous reset
        // applied away from any clock edge must clear outputs immediately.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 16'd200, 16'd100, 1'b0);
        check("pre_reset_head", 64'({out_valid, out_intensity, out_index}),
              64'({1'b1, 16'd200, 16'd2}));
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_clears",
              64'({out_valid, out_intensity, out_index, confirmed, overflow}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b0, 16'd0, 16'd100, 1'b1);
        check("post_reset_empty", 64'({out_valid, confirmed}), 64'd0);
        // Index restarts at zero after the reset.
        for (int i = 0; i < 3; i++) step(1'b1, 16'd150, 16'd100, 1'b0);
        check("post_reset_index", 64'({out_valid, out_intensity, out_index, confirmed}),
              64'({1'b1, 16'd150, 16'd2, 1'b1}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
